asym_width_fifo: RTL and testbench

Single-clock FIFO whose write and read ports differ in width by an integer ratio in either direction, with AXI-stream valid/ready handshakes on both sides. It is the successor to the sliding-window unit's narrow/wide buffer RAM. It adds flow control, occupancy tracking, a registered two-stage read pipeline with full throughput, and optional zero-padding of partial frames. It sits between a width-mismatched producer (e.g. the input stream) and a consumer (e.g. the window generator or the MVAU input).

---
 rtl/asym_width_fifo.sv | 132 +++++++++++++
 tb/tb_asym_width_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/asym_width_fifo.sv
// asym_width_fifo: single-clock width-converting FIFO, AXI-stream handshakes.
// Define ASYM_FIFO_PAD_EN to add in_last and zero-padding of partial frames.
module asym_width_fifo #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 32,
  parameter int DEPTH     = 64,
  parameter     RAM_STYLE = "auto"
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [WIDTH_IN-1:0]      in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
`ifdef ASYM_FIFO_PAD_EN
  input  logic                     in_last,
`endif
  output logic [WIDTH_OUT-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int W     = (WIDTH_IN < WIDTH_OUT) ? WIDTH_IN : WIDTH_OUT;
  localparam int R_IN  = WIDTH_IN / W;
  localparam int R_OUT = WIDTH_OUT / W;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

`ifdef ASYM_FIFO_PAD_EN
  localparam bit PAD = (WIDTH_IN < WIDTH_OUT);
  logic last;
  assign last = in_last;
`else
  localparam bit PAD = 1'b0;
  logic last;
  assign last = 1'b0;
`endif

  (* ram_style = RAM_STYLE *)
  logic [W-1:0] mem [DEPTH];

  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pad_q, pad_d;
  logic                 s1_v_q, s1_v_d;
  logic                 s2_v_q, s2_v_d;
  logic [WIDTH_OUT-1:0] s1_q, s2_q;
  logic [WIDTH_OUT-1:0] rd_word;
  logic [AW-1:0]        wptr_nxt;
  logic [1:0]           inflight;
  logic                 wr, room, full_go, pad_go, launch, move, arm;

  assign in_ready = !pad_q && ((CW'(DEPTH) - cnt_q) >= CW'(R_IN));
  assign wr       = in_valid && in_ready;
  assign wptr_nxt = wptr_q + AW'(R_IN);

  // A word leaving stage 2 this cycle frees its credit immediately.
  assign inflight = {1'b0, s1_v_q} + {1'b0, s2_v_q}
                  - {1'b0, s2_v_q && out_ready};
  assign room     = inflight < 2'd2;
  assign full_go  = cnt_q >= CW'(R_OUT);
  assign pad_go   = room && PAD && pad_q && !full_go
                  && (cnt_q != '0);
  assign launch   = room && (full_go || pad_go);
  assign move     = s1_v_q && (!s2_v_q || out_ready);
  assign arm      = PAD && wr && last
                  && ((wptr_nxt & AW'(R_OUT - 1)) != '0);

  always_comb begin
    rd_word = '0;
    for (int j = 0; j < R_OUT; j++) begin
      if (!(pad_go && (CW'(j) >= cnt_q)))
        rd_word[j*W +: W] = mem[rptr_q + AW'(j)];
    end
  end

  always_comb begin
    wptr_d = wr ? wptr_nxt : wptr_q;
    rptr_d = launch ? rptr_q + AW'(R_OUT) : rptr_q;
    cnt_d  = cnt_q;
    if (wr)
      cnt_d = cnt_d + CW'(R_IN);
    if (launch && !pad_go)
      cnt_d = cnt_d - CW'(R_OUT);
    pad_d  = pad_q || arm;
    // Padding realigns both pointers to the next word boundary.
    if (pad_go) begin
      wptr_d = rptr_q + AW'(R_OUT);
      cnt_d  = '0;
      pad_d  = 1'b0;
    end
    s1_v_d = launch || (s1_v_q && !move);
    s2_v_d = move || (s2_v_q && !out_ready);
  end

  always_ff @(posedge ap_clk) begin
    if (wr) begin
      for (int i = 0; i < R_IN; i++)
        mem[wptr_q + AW'(i)] <= in_data[i*W +: W];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      pad_q  <= 1'b0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      pad_q  <= pad_d;
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      if (launch)
        s1_q <= rd_word;
      if (move)
        s2_q <= s1_q;
    end
  end

  assign out_data  = s2_q;
  assign out_valid = s2_v_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_asym_width_fifo.sv
// tb_asym_width_fifo: directed checks of 8->32 and 32->8 FIFO instances.
// Padding checks are compiled in when ASYM_FIFO_PAD_EN is defined.
module tb_asym_width_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  u_din;
  logic        u_iv, u_ir, u_ov, u_or;
  logic [31:0] u_dout;
  logic [4:0]  u_cnt;
  logic [31:0] d_din;
  logic        d_iv, d_ir, d_ov, d_or;
  logic [7:0]  d_dout;
  logic [4:0]  d_cnt;
`ifdef ASYM_FIFO_PAD_EN
  logic        u_last, d_last;
`endif

  int n_run  = 0;
  int n_fail = 0;

  asym_width_fifo #(.WIDTH_IN(8), .WIDTH_OUT(32), .DEPTH(16)) u_up (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in_data(u_din), .in_valid(u_iv), .in_ready(u_ir),
`ifdef ASYM_FIFO_PAD_EN
    .in_last(u_last),
`endif
    .out_data(u_dout), .out_valid(u_ov), .out_ready(u_or),
    .count(u_cnt)
  );

  asym_width_fifo #(.WIDTH_IN(32), .WIDTH_OUT(8), .DEPTH(16)) u_dn (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in_data(d_din), .in_valid(d_iv), .in_ready(d_ir),
`ifdef ASYM_FIFO_PAD_EN
    .in_last(d_last),
`endif
    .out_data(d_dout), .out_valid(d_ov), .out_ready(d_or),
    .count(d_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int idx, nb, nrecv;
    logic        prev_stall;
    logic [31:0] prev_data, exp_w;
    rst_n = 1'b0;
    u_din = '0; u_iv = 1'b0; u_or = 1'b0;
    d_din = '0; d_iv = 1'b0; d_or = 1'b0;
`ifdef ASYM_FIFO_PAD_EN
    u_last = 1'b0; d_last = 1'b0;
`endif
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    chk("rst_in_ready", u_ir, 1);
    chk("rst_out_valid", u_ov, 0);
    chk("rst_out_data", u_dout, 0);
    chk("rst_count", u_cnt, 0);
    chk("rst_dn_count", d_cnt, 0);
    chk("rst_dn_ready", d_ir, 1);

    // 8->32 basic packing and latency
    u_or = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_din = 8'(17 * (i + 1));
      u_iv  = 1'b1;
      tick;
    end
    u_iv = 1'b0;
    chk("lat_count4", u_cnt, 4);
    chk("lat_k_valid", u_ov, 0);
    tick;
    chk("lat_k1_valid", u_ov, 0);
    chk("lat_k1_count", u_cnt, 0);
    tick;
    chk("lat_k2_valid", u_ov, 1);
    chk("lat_k2_data", u_dout, 32'h44332211);
    tick;
    chk("lat_consumed", u_ov, 0);
    chk("lat_ready", u_ir, 1);

    // fill under backpressure: 24 slots accepted, rest rejected
    u_or = 1'b0;
    for (int i = 0; i < 28; i++) begin
      u_din = 8'(i + 1);
      u_iv  = 1'b1;
      if (i == 23) chk("fill_ready_23", u_ir, 1);
      if (i == 24) chk("fill_ready_24", u_ir, 0);
      tick;
    end
    u_iv = 1'b0;
    chk("fill_count", u_cnt, 16);
    chk("fill_ready", u_ir, 0);
    chk("fill_valid", u_ov, 1);
    chk("fill_head", u_dout, 32'h04030201);
    u_or = 1'b1;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (u_ov) begin
        exp_w = {8'(4*idx+4), 8'(4*idx+3), 8'(4*idx+2), 8'(4*idx+1)};
        chk("drain_word", u_dout, exp_w);
        idx++;
      end
      tick;
    end
    chk("drain_words", idx, 6);
    chk("drain_count", u_cnt, 0);
    chk("drain_ready", u_ir, 1);

    // 32->8 unpacking, one byte per cycle
    d_or  = 1'b1;
    d_din = 32'hDDCCBBAA;
    d_iv  = 1'b1;
    tick;
    d_iv = 1'b0;
    chk("dn_count4", d_cnt, 4);
    tick;
    chk("dn_k1_valid", d_ov, 0);
    tick;
    chk("dn_b0", {d_ov, d_dout}, 9'h1AA);
    tick;
    chk("dn_b1", {d_ov, d_dout}, 9'h1BB);
    tick;
    chk("dn_b2", {d_ov, d_dout}, 9'h1CC);
    tick;
    chk("dn_b3", {d_ov, d_dout}, 9'h1DD);
    tick;
    chk("dn_done_valid", d_ov, 0);
    chk("dn_done_count", d_cnt, 0);

    // random producer, toggling consumer, byte stream 0,1,2,...
    nb = 0; nrecv = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 6000 && nrecv < 300; c++) begin
      if (prev_stall) begin
        chk("stall_valid", u_ov, 1);
        chk("stall_data", u_dout, prev_data);
      end
      u_or  = c[0];
      u_iv  = (nb < 1200) && ($urandom_range(0, 1) == 1);
      u_din = 8'(nb);
      if (u_iv && u_ir) nb++;
      if (u_ov && u_or) begin
        exp_w = {8'(4*nrecv+3), 8'(4*nrecv+2), 8'(4*nrecv+1), 8'(4*nrecv)};
        chk("rand_word", u_dout, exp_w);
        nrecv++;
      end
      prev_stall = u_ov && !u_or;
      prev_data  = u_dout;
      tick;
    end
    u_iv = 1'b0;
    u_or = 1'b1;
    chk("rand_words", nrecv, 300);
    tick;
    chk("rand_count", u_cnt, 0);
    chk("rand_valid", u_ov, 0);

    // reset in the middle of traffic
    u_or = 1'b0;
    for (int i = 0; i < 16; i++) begin
      u_din = 8'(8'h30 + i);
      u_iv  = 1'b1;
      tick;
    end
    u_iv = 1'b0;
    chk("pre_rst_count", u_cnt, 8);
    chk("pre_rst_valid", u_ov, 1);
    chk("pre_rst_data", u_dout, 32'h33323130);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", u_ov, 0);
    chk("mid_rst_data", u_dout, 0);
    chk("mid_rst_count", u_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    u_or = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_din = 8'(8'h5A + 17 * i);
      u_iv  = 1'b1;
      tick;
    end
    u_iv = 1'b0;
    tick;
    tick;
    chk("post_rst_valid", u_ov, 1);
    chk("post_rst_data", u_dout, 32'h8D7C6B5A);
    tick;

`ifdef ASYM_FIFO_PAD_EN
    // partial frame padded with zero lanes
    u_din = 8'hA1; u_iv = 1'b1; u_last = 1'b0;
    tick;
    u_din = 8'hB2; u_last = 1'b1;
    tick;
    u_iv = 1'b0; u_last = 1'b0;
    chk("pad_armed_ready", u_ir, 0);
    chk("pad_armed_count", u_cnt, 2);
    tick;
    chk("pad_launch_ready", u_ir, 1);
    chk("pad_launch_count", u_cnt, 0);
    tick;
    chk("pad_valid", u_ov, 1);
    chk("pad_data", u_dout, 32'h0000B2A1);
    tick;
    for (int i = 0; i < 4; i++) begin
      u_din = 8'(8'hC3 + 17 * i);
      u_iv  = 1'b1;
      tick;
    end
    u_iv = 1'b0;
    tick;
    tick;
    chk("pad_next_data", u_dout, 32'hF6E5D4C3);
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
